// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM block fill / block copy initiator for the 8192 x 32 on-chip RAM.
// Define ONCHIP_MEM_COPY_INCR_FILL_EN to make the fill pattern increment after every write.
module onchip_mem_copy_master #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  op,
    input  logic [ADDR_W-1:0]     src_addr,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [CNT_W-1:0]      count,
    input  logic [DATA_W-1:0]     fill_data,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_W-1:0]     address,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    output logic                  clken,
    input  logic [DATA_W-1:0]     readdata
);

    // state   | meaning
    // IDLE    | waiting for start
    // FILL_WR | one pattern write per cycle
    // CP_RD   | read issued at source pointer
    // CP_CAP  | read data returns, captured into hold register
    // CP_WR   | hold register written to destination pointer
    // FIN     | one-cycle done pulse
    typedef enum logic [2:0] {IDLE, FILL_WR, CP_RD, CP_CAP, CP_WR, FIN} state_t;

`ifdef ONCHIP_MEM_COPY_INCR_FILL_EN
    localparam logic [DATA_W-1:0] PAT_STEP = DATA_W'(1);
`else
    localparam logic [DATA_W-1:0] PAT_STEP = '0;
`endif

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  src_q, src_d;
    logic [ADDR_W-1:0]  dst_q, dst_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]  pat_q, pat_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               aborted_q, aborted_d;
    logic               clken_q, clken_d;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        pat_d      = pat_q;
        hold_d     = hold_q;
        aborted_d  = aborted_q;
        clken_d    = 1'b1;
        done       = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d     = src_addr;
                    dst_d     = dst_addr;
                    rem_d     = count;
                    pat_d     = fill_data;
                    aborted_d = 1'b0;
                    if (count == '0)
                        state_d = FIN;
                    else
                        state_d = op ? CP_RD : FILL_WR;
                end
            end
            FILL_WR: begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = dst_q;
                writedata  = pat_q;
                dst_d      = dst_q + 1'b1;
                rem_d      = rem_q - 1'b1;
                pat_d      = pat_q + PAT_STEP;
                if (rem_q == CNT_W'(1))
                    state_d = FIN;
            end
            CP_RD: begin
                chipselect = 1'b1;
                address    = src_q;
                state_d    = CP_CAP;
            end
            CP_CAP: begin
                hold_d  = readdata;
                state_d = CP_WR;
            end
            CP_WR: begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = dst_q;
                writedata  = hold_q;
                src_d      = src_q + 1'b1;
                dst_d      = dst_q + 1'b1;
                rem_d      = rem_q - 1'b1;
                state_d    = (rem_q == CNT_W'(1)) ? FIN : CP_RD;
            end
            FIN: begin
                done    = ~abort;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides any busy-state transition; the current access still goes out this cycle.
        if (state_q != IDLE && abort) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            pat_q     <= '0;
            hold_q    <= '0;
            aborted_q <= 1'b0;
            clken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            pat_q     <= pat_d;
            hold_q    <= hold_d;
            aborted_q <= aborted_d;
            clken_q   <= clken_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign aborted    = aborted_q;
    assign byteenable = '1;
    assign clken      = clken_q;

endmodule
